// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler
// Triple-buffer scheduler for the shared DDR frame store. Rotates three slot
// tags between the camera writer, the "latest complete" holder and the HDMI
// reader, so the writer never touches the slot being scanned out and the
// reader always picks up the newest complete frame.
// Optional statistics counters are built only when FB_STATS_EN is defined;
// otherwise the three counter ports are tied to zero.
module frame_buffer_scheduler #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0009_6000
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic        wr_frame_done,
    input  logic        rd_frame_start,
    input  logic        freeze,
    output logic [31:0] wr_base_addr,
    output logic [31:0] rd_base_addr,
    output logic [1:0]  wr_buf_idx,
    output logic [1:0]  rd_buf_idx,
    output logic        rd_valid,
    output logic        rd_new_frame,
    output logic [15:0] frames_written,
    output logic [15:0] frames_dropped,
    output logic [15:0] frames_repeated
);

    localparam logic [31:0] SLOT1_ADDR = BASE_ADDR + FRAME_STRIDE;
    localparam logic [31:0] SLOT2_ADDR = BASE_ADDR + FRAME_STRIDE + FRAME_STRIDE;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_EMPTY = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  w_idx_q, w_idx_d;
    logic [1:0]  l_idx_q, l_idx_d;
    logic [1:0]  r_idx_q, r_idx_d;
    logic        l_fresh_q, l_fresh_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_new_frame_q, rd_new_frame_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] rd_addr_q, rd_addr_d;

    // Slot index to byte address as a constant select; index 3 never occurs.
    function automatic logic [31:0] slot_addr(input logic [1:0] idx);
        logic [31:0] a;
        case (idx)
            2'd0:    a = BASE_ADDR;
            2'd1:    a = SLOT1_ADDR;
            2'd2:    a = SLOT2_ADDR;
            default: a = BASE_ADDR;
        endcase
        return a;
    endfunction

    // Next-state logic: write swap first, then the read rule on its result.
    always_comb begin
        state_d        = state_q;
        w_idx_d        = w_idx_q;
        l_idx_d        = l_idx_q;
        r_idx_d        = r_idx_q;
        l_fresh_d      = l_fresh_q;
        rd_valid_d     = rd_valid_q;
        rd_new_frame_d = 1'b0;
        case (state_q)
            S_INIT: begin
                state_d = S_EMPTY;
            end
            S_EMPTY, S_RUN: begin
                if (wr_frame_done) begin
                    w_idx_d   = l_idx_q;
                    l_idx_d   = w_idx_q;
                    l_fresh_d = 1'b1;
                end else begin
                    l_fresh_d = l_fresh_q;
                end
                if (rd_frame_start && l_fresh_d && !freeze) begin
                    r_idx_d        = l_idx_d;
                    l_idx_d        = r_idx_q;
                    l_fresh_d      = 1'b0;
                    rd_new_frame_d = 1'b1;
                    rd_valid_d     = 1'b1;
                    state_d        = S_RUN;
                end else begin
                    rd_new_frame_d = 1'b0;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        // In S_INIT this loads the addresses of the reset-time slots.
        wr_addr_d = slot_addr(w_idx_d);
        rd_addr_d = slot_addr(r_idx_d);
    end

    // State, slot tags and registered outputs.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q        <= S_INIT;
            w_idx_q        <= 2'd0;
            l_idx_q        <= 2'd1;
            r_idx_q        <= 2'd2;
            l_fresh_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_new_frame_q <= 1'b0;
            wr_addr_q      <= 32'h0000_0000;
            rd_addr_q      <= 32'h0000_0000;
        end else begin
            state_q        <= state_d;
            w_idx_q        <= w_idx_d;
            l_idx_q        <= l_idx_d;
            r_idx_q        <= r_idx_d;
            l_fresh_q      <= l_fresh_d;
            rd_valid_q     <= rd_valid_d;
            rd_new_frame_q <= rd_new_frame_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
        end
    end

    assign wr_base_addr = wr_addr_q;
    assign rd_base_addr = rd_addr_q;
    assign wr_buf_idx   = w_idx_q;
    assign rd_buf_idx   = r_idx_q;
    assign rd_valid     = rd_valid_q;
    assign rd_new_frame = rd_new_frame_q;

`ifdef FB_STATS_EN
    logic        active_s;
    logic        written_s;
    logic        dropped_s;
    logic        repeated_s;
    logic [15:0] written_q, written_d;
    logic [15:0] dropped_q, dropped_d;
    logic [15:0] repeated_q, repeated_d;

    // Statistics events; a read that finds nothing new only counts once running.
    always_comb begin
        active_s   = (state_q == S_EMPTY) || (state_q == S_RUN);
        written_s  = active_s && wr_frame_done;
        dropped_s  = written_s && l_fresh_q;
        repeated_s = (state_q == S_RUN) && rd_frame_start &&
                     (freeze || !(wr_frame_done || l_fresh_q));
        written_d  = written_s  ? written_q  + 16'd1 : written_q;
        dropped_d  = dropped_s  ? dropped_q  + 16'd1 : dropped_q;
        repeated_d = repeated_s ? repeated_q + 16'd1 : repeated_q;
    end

    // Statistics counters, wrapping modulo 2^16.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            written_q  <= 16'h0000;
            dropped_q  <= 16'h0000;
            repeated_q <= 16'h0000;
        end else begin
            written_q  <= written_d;
            dropped_q  <= dropped_d;
            repeated_q <= repeated_d;
        end
    end

    assign frames_written  = written_q;
    assign frames_dropped  = dropped_q;
    assign frames_repeated = repeated_q;
`else
    assign frames_written  = 16'h0000;
    assign frames_dropped  = 16'h0000;
    assign frames_repeated = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Testbench for frame_buffer_scheduler: directed steps followed by random
// traffic, all checked against a slot-role model kept in the bench.
module tb_frame_buffer_scheduler;

    logic        clk_100Mhz = 1'b0;
    logic        rst = 1'b1;
    logic        wr_frame_done = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        freeze = 1'b0;
    logic [31:0] wr_base_addr, rd_base_addr;
    logic [1:0]  wr_buf_idx, rd_buf_idx;
    logic        rd_valid, rd_new_frame;
    logic [15:0] frames_written, frames_dropped, frames_repeated;

    int errors = 0;
    int checks = 0;

    // Model: which slot plays which role, plus bookkeeping.
    int          m_w, m_l, m_r;
    bit          m_fresh, m_init, m_run, m_valid, m_new;
    logic [31:0] m_wa, m_ra;
    logic [15:0] m_fw, m_fd, m_fr;

    always #5 clk_100Mhz = ~clk_100Mhz;

    frame_buffer_scheduler dut (
        .clk_100Mhz      (clk_100Mhz),
        .rst             (rst),
        .wr_frame_done   (wr_frame_done),
        .rd_frame_start  (rd_frame_start),
        .freeze          (freeze),
        .wr_base_addr    (wr_base_addr),
        .rd_base_addr    (rd_base_addr),
        .wr_buf_idx      (wr_buf_idx),
        .rd_buf_idx      (rd_buf_idx),
        .rd_valid        (rd_valid),
        .rd_new_frame    (rd_new_frame),
        .frames_written  (frames_written),
        .frames_dropped  (frames_dropped),
        .frames_repeated (frames_repeated)
    );

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0009_6000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit wr, input bit rd, input bit fz);
        int t;
        m_new = 1'b0;
        if (r) begin
            m_w = 0; m_l = 1; m_r = 2;
            m_fresh = 1'b0; m_init = 1'b1; m_run = 1'b0; m_valid = 1'b0;
            m_wa = 32'h0; m_ra = 32'h0;
            m_fw = 16'h0; m_fd = 16'h0; m_fr = 16'h0;
        end else if (m_init) begin
            m_init = 1'b0;
            m_wa = addr_of(m_w);
            m_ra = addr_of(m_r);
        end else begin
            if (wr) begin
                t = m_w; m_w = m_l; m_l = t;
                m_fw = m_fw + 16'd1;
                if (m_fresh) m_fd = m_fd + 16'd1;
                m_fresh = 1'b1;
            end
            if (rd) begin
                if (m_fresh && !fz) begin
                    t = m_r; m_r = m_l; m_l = t;
                    m_fresh = 1'b0; m_new = 1'b1; m_valid = 1'b1; m_run = 1'b1;
                end else if (m_run) begin
                    m_fr = m_fr + 16'd1;
                end
            end
            m_wa = addr_of(m_w);
            m_ra = addr_of(m_r);
        end
    endtask

    task automatic check_all();
        chk("wr_base_addr", wr_base_addr, m_wa);
        chk("rd_base_addr", rd_base_addr, m_ra);
        chk("wr_buf_idx", {30'd0, wr_buf_idx}, 32'(m_w));
        chk("rd_buf_idx", {30'd0, rd_buf_idx}, 32'(m_r));
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        chk("rd_new_frame", {31'd0, rd_new_frame}, {31'd0, m_new});
        chk("idx_distinct", {31'd0, (wr_buf_idx != rd_buf_idx) && (wr_buf_idx < 2'd3)
                                   && (rd_buf_idx < 2'd3)}, 32'd1);
`ifdef FB_STATS_EN
        chk("frames_written", {16'd0, frames_written}, {16'd0, m_fw});
        chk("frames_dropped", {16'd0, frames_dropped}, {16'd0, m_fd});
        chk("frames_repeated", {16'd0, frames_repeated}, {16'd0, m_fr});
`else
        chk("frames_written", {16'd0, frames_written}, 32'd0);
        chk("frames_dropped", {16'd0, frames_dropped}, 32'd0);
        chk("frames_repeated", {16'd0, frames_repeated}, 32'd0);
`endif
    endtask

    // One clock: drive inputs, let the edge pass, update model, compare.
    task automatic cycle(input bit r, input bit wr, input bit rd, input bit fz);
        rst = r; wr_frame_done = wr; rd_frame_start = rd; freeze = fz;
        @(posedge clk_100Mhz);
        model_step(r, wr, rd, fz);
        #1;
        rst = 1'b0; wr_frame_done = 1'b0; rd_frame_start = 1'b0;
        check_all();
    endtask

    initial begin
        bit r, wr, rd, fz;
        // Reset, then INIT plus four idle cycles.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_wr_addr_const", wr_base_addr, 32'h1000_0000);
        chk("idle_rd_addr_const", rd_base_addr, 32'h1012_C000);

        // Pulse ignored during INIT.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // One write, then one read.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wr_slot1_const", wr_base_addr, 32'h1009_6000);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rd_slot0_const", rd_base_addr, 32'h1000_0000);
        chk("rd_new_pulse_const", {31'd0, rd_new_frame}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Three writes with no read, then a read.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // One write, two reads: second one repeats.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("repeat_no_pulse_const", {31'd0, rd_new_frame}, 32'd0);

        // Same-cycle write and read with nothing fresh.
        cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Freeze with a fresh frame pending, then release.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset right after a write.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_wr_addr_const", wr_base_addr, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom % 97) == 0;
            wr = ($urandom % 3) == 0;
            rd = ($urandom % 3) == 0;
            fz = ($urandom % 4) == 0;
            cycle(r, wr, rd, fz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Triple-buffer scheduler for the DDR frame store shared by the camera-side AXI4 writer and the HDMI-side AXI4 reader. It owns three frame slots in PS DDR and hands each master a base address, so the writer never overwrites the frame being scanned out. It also ensures the reader always gets the newest complete frame. It sits in the `clk_100Mhz` AXI domain between the frame-event synchronizers and the base-address inputs of the writer and reader.

## Interface
Parameters:
- `BASE_ADDR`, 32'h1000_0000, byte address of slot 0 (8-byte aligned).
- `FRAME_STRIDE`, 32'h0009_6000, bytes per slot (640x480x16 bpp).

Ports:
- `clk_100Mhz`, in, 1, sole clock; AXI clock.
- `rst`, in, 1, synchronous, active-high reset.
- `wr_frame_done`, in, 1, one-cycle pulse; writer's final B response of a frame has been accepted.
- `rd_frame_start`, in, 1, one-cycle pulse; reader is about to fetch line 0 of the next display frame.
- `freeze`, in, 1, level; while high the reader slot is never swapped.
- `wr_base_addr`, out, 32, slot address the writer fills.
- `rd_base_addr`, out, 32, slot address the reader fetches.
- `wr_buf_idx`, out, 2, writer slot index (0..2).
- `rd_buf_idx`, out, 2, reader slot index (0..2).
- `rd_valid`, out, 1, reader slot holds a complete frame; when low, the reader outputs black.
- `rd_new_frame`, out, 1, one-cycle pulse; reader slot changed this frame.
- `frames_written`, `frames_dropped`, `frames_repeated`, out, 16 each, statistics counters (see Configuration).

Both input pulses are already synchronized to `clk_100Mhz` upstream.

## Operation
- Internal tags: `w_idx`, `l_idx` (latest complete), `r_idx`; always a permutation of {0,1,2}. `l_fresh` = latest slot is complete and not yet shown.
- FSM states:
  - `S_INIT`: one cycle after reset; loads the address registers.
  - `S_EMPTY`: no frame completed yet; `rd_valid`=0.
  - `S_RUN`: normal operation.
  - Transitions: `S_INIT`→`S_EMPTY` unconditionally. `S_EMPTY`→`S_RUN` on the first reader swap. `S_RUN` persists until `rst`.
- On `wr_frame_done`:
  - swap `w_idx`↔`l_idx`;
  - if `l_fresh` was already 1, the overwritten latest frame counts as dropped;
  - set `l_fresh`=1.
- On `rd_frame_start`:
  - if `l_fresh`=1 and `freeze`=0: swap `r_idx`↔`l_idx`, clear `l_fresh`, pulse `rd_new_frame`, set `rd_valid`=1;
  - otherwise the reader keeps its slot and the frame counts as repeated, but only in `S_RUN`.
- Both pulses in the same cycle: apply the write swap first, then the read rule on the result. With `l_fresh`=0 before the cycle, the outcome is: w=old l, r=old w, l=old r, `l_fresh`=0, nothing dropped.
- Pulses in `S_INIT` are ignored.
- Address mapping: `idx*FRAME_STRIDE + BASE_ADDR`, computed as a 3-way constant select (no multiplier). 32-bit arithmetic; overflow is a configuration error and is not checked.

## Timing
- Reset values: `w_idx`=0, `l_idx`=1, `r_idx`=2, `l_fresh`=0, `rd_valid`=0, `rd_new_frame`=0, all counters 0.
- In `S_INIT`, `wr_base_addr`/`rd_base_addr` are 0, then take the slot 0 and slot 2 addresses one cycle later.
- Latency: an event in cycle N updates the indices at edge N+1. The addresses and `rd_new_frame` are registered and valid at edge N+1. Consumers sample the base address at the start of their next burst.
- `rst` mid-frame returns to reset values within one cycle, regardless of any outstanding AXI traffic. The writer and reader share the same `rst`.
- `freeze` is sampled only in the cycle of `rd_frame_start`.

## Configuration
- `FB_STATS_EN` defined:
  - `frames_written` increments on every `wr_frame_done`;
  - `frames_dropped` increments on every dropped frame;
  - `frames_repeated` increments on every repeated frame;
  - all three wrap modulo 2^16 and are reset by `rst`.
- `FB_STATS_EN` undefined: the counters are not built and the three ports are tied to 16'h0000. The port list is unchanged.

## Test plan
- Reset, then idle 4 cycles → `wr_base_addr`=32'h1000_0000, `rd_base_addr`=32'h1012_C000, `rd_valid`=0, `rd_new_frame`=0.
- One `wr_frame_done`, then one `rd_frame_start` → writer moves to slot 1 (32'h1009_6000). Reader then moves to slot 0 with a `rd_new_frame` pulse and `rd_valid`=1. `frames_written`=1.
- Three `wr_frame_done` pulses with no read → `frames_dropped`=2. The next `rd_frame_start` gets the last completed slot. Indices remain a permutation at every cycle.
- Two `rd_frame_start` pulses after one write → the second keeps the reader slot, gives no `rd_new_frame`, and sets `frames_repeated`=1.
- Same-cycle `wr_frame_done` and `rd_frame_start` in `S_RUN` with `l_fresh`=0 → the reader gets the just-written slot and the writer gets the old latest slot.
- `freeze`=1 with a fresh frame pending → the reader slot is unchanged. After `freeze`=0, the next `rd_frame_start` swaps.
- `rst` asserted one cycle after `wr_frame_done` → all outputs return to reset values by the next edge.
